operand_entry: RTL

Sequential front end that replaces the combinational button decoder feeding the ALU. It builds the two 16-bit ALU operands one hex nibble at a time from the board's 4 switches, using debounced push buttons. It presents the operands on stable registered outputs with a one-cycle `operands_valid` strobe and a level `ready`, which the ALU and 7-segment path consume directly.

---
 rtl/operand_entry.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - debounced hex-nibble operand entry front end for the ALU

// Debouncer: accept a level change after DEBOUNCE_CYCLES stable cycles, emit one-cycle rising event
module operand_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_event
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_db;
  logic          r_db_d;
  logic [CW-1:0] r_cnt;

  // Count consecutive cycles where the input disagrees with the debounced level
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (i_level == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_db  <= i_level;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_db_d <= 1'b0;
    else          r_db_d <= r_db;
  end

  assign o_event = r_db & ~r_db_d;

endmodule

module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_nibble,
  input  logic        i_btn_enter,
  input  logic        i_btn_clear,
  output logic [15:0] o_a,
  output logic [15:0] o_b,
  output logic        o_ready,
  output logic        o_operands_valid,
  output logic [1:0]  o_phase,
  output logic [1:0]  o_nibble_idx
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    READY   = 2'd2
  } phase_t;

  logic [3:0]  r_nib_s1, r_nib_s2;
  logic        r_ent_s1, r_ent_s2;
  logic        r_clr_s1, r_clr_s2;

  phase_t      r_phase, w_phase_nx;
  logic [15:0] r_a, w_a_nx;
  logic [15:0] r_b, w_b_nx;
  logic [1:0]  r_idx, w_idx_nx;
  logic        r_ready, w_ready_nx;
  logic        r_valid, w_valid_nx;

  logic        w_ent_ev;
  logic        w_clr_ev;

  // Two-flop synchronizers for the asynchronous switch and button inputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_nib_s1 <= 4'd0;
      r_nib_s2 <= 4'd0;
      r_ent_s1 <= 1'b0;
      r_ent_s2 <= 1'b0;
      r_clr_s1 <= 1'b0;
      r_clr_s2 <= 1'b0;
    end else begin
      r_nib_s1 <= i_nibble;
      r_nib_s2 <= r_nib_s1;
      r_ent_s1 <= i_btn_enter;
      r_ent_s2 <= r_ent_s1;
      r_clr_s1 <= i_btn_clear;
      r_clr_s2 <= r_clr_s1;
    end
  end

  operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_level (r_ent_s2),
    .o_event (w_ent_ev)
  );

  operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_level (r_clr_s2),
    .o_event (w_clr_ev)
  );

  // Entry state and operand registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase <= ENTER_A;
      r_a     <= 16'd0;
      r_b     <= 16'd0;
      r_idx   <= 2'd0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_phase <= w_phase_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_idx   <= w_idx_nx;
      r_ready <= w_ready_nx;
      r_valid <= w_valid_nx;
    end
  end

  // Next-state logic: clear beats enter; READY restarts entry without consuming the nibble
  always_comb begin
    w_phase_nx = r_phase;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_idx_nx   = r_idx;
    w_ready_nx = r_ready;
    w_valid_nx = 1'b0;
    if (w_clr_ev) begin
      w_phase_nx = ENTER_A;
      w_a_nx     = 16'd0;
      w_b_nx     = 16'd0;
      w_idx_nx   = 2'd0;
      w_ready_nx = 1'b0;
    end else if (w_ent_ev) begin
      case (r_phase)
        ENTER_A: begin
          w_a_nx = {r_a[11:0], r_nib_s2};
          if (r_idx == 2'd3) begin
            w_phase_nx = ENTER_B;
            w_idx_nx   = 2'd0;
          end else begin
            w_idx_nx = r_idx + 2'd1;
          end
        end
        ENTER_B: begin
          w_b_nx = {r_b[11:0], r_nib_s2};
          if (r_idx == 2'd3) begin
            w_phase_nx = READY;
            w_idx_nx   = 2'd0;
            w_ready_nx = 1'b1;
            w_valid_nx = 1'b1;
          end else begin
            w_idx_nx = r_idx + 2'd1;
          end
        end
        READY: begin
          w_phase_nx = ENTER_A;
          w_a_nx     = 16'd0;
          w_b_nx     = 16'd0;
          w_idx_nx   = 2'd0;
          w_ready_nx = 1'b0;
        end
        default: begin
          w_phase_nx = ENTER_A;
          w_a_nx     = 16'd0;
          w_b_nx     = 16'd0;
          w_idx_nx   = 2'd0;
          w_ready_nx = 1'b0;
        end
      endcase
    end
  end

  assign o_a              = r_a;
  assign o_b              = r_b;
  assign o_ready          = r_ready;
  assign o_operands_valid = r_valid;
  assign o_phase          = r_phase;
  assign o_nibble_idx     = r_idx;

endmodule
